// File: rtl/maze_mem_responder.sv
// Maze memory responder: serial grid load, 1-cycle solver reads, visited-cell marking and statistics.
// Build option: define MAZE_VISITED_AS_WALL_EN to report visited cells as walls on reads.
module maze_mem_responder #(
  parameter int MAZE_W = 6,
  parameter int CNT_W  = 2*MAZE_W+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic              load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic [MAZE_W-1:0] row,
  input  logic [MAZE_W-1:0] col,
  input  logic              maze_oe,
  input  logic              maze_we,
  output logic              maze_in,
  output logic [CNT_W-1:0]  visited_count,
  output logic              wall_write_err,
  output logic              early_access_err
);

  localparam int AW    = 2*MAZE_W;
  localparam int CELLS = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CELLS);

  typedef enum logic [1:0] {ST_RESET, ST_LOAD, ST_SERVE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CELLS-1:0] wall_q, vis_q;
  logic             maze_in_q, maze_in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             werr_q, werr_d;
  logic             eerr_q, eerr_d;

  logic [AW-1:0] idx;
  logic          cell_wall, cell_vis, rd_bit;
  logic          beat, mark;

  assign idx       = {row, col};
  assign cell_wall = wall_q[idx];
  assign cell_vis  = vis_q[idx];

`ifdef MAZE_VISITED_AS_WALL_EN
  assign rd_bit = cell_wall | cell_vis;
`else
  assign rd_bit = cell_wall;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      addr_q    <= '0;
      maze_in_q <= 1'b1;
      cnt_q     <= '0;
      werr_q    <= 1'b0;
      eerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      maze_in_q <= maze_in_d;
      cnt_q     <= cnt_d;
      werr_q    <= werr_d;
      eerr_q    <= eerr_d;
    end
  end

  // Grid storage is deliberately not reset; every cell is rewritten by the next load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (beat) begin
        wall_q[addr_q] <= load_data;
        vis_q[addr_q]  <= 1'b0;
      end else if (mark) begin
        vis_q[idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    maze_in_d  = maze_in_q;
    cnt_d      = cnt_q;
    werr_d     = werr_q;
    eerr_d     = eerr_q;
    load_ready = 1'b0;
    load_done  = 1'b0;
    beat       = 1'b0;
    mark       = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_LOAD;
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          beat   = 1'b1;
          addr_d = addr_q + AW'(1);
          if (addr_q == {AW{1'b1}}) state_d = ST_SERVE;
        end
      end
      ST_SERVE: load_done = 1'b1;
      default:  state_d = ST_RESET;
    endcase

    // Reads sample the grid before any same-cycle mark lands.
    if (state_q == ST_SERVE) begin
      if (maze_oe) maze_in_d = rd_bit;
      if (maze_we) begin
        if (cell_wall) begin
          werr_d = 1'b1;
        end else if (!cell_vis) begin
          mark = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      maze_in_d = 1'b1;
      if (maze_oe || maze_we) eerr_d = 1'b1;
    end
  end

  assign maze_in          = maze_in_q;
  assign visited_count    = cnt_q;
  assign wall_write_err   = werr_q;
  assign early_access_err = eerr_q;

endmodule

// File: tb/tb_maze_mem_responder.sv
// Self-checking bench for maze_mem_responder: randomized load/serve traffic against a cell-level reference model.
module tb_maze_mem_responder;

  localparam int MAZE_W = 6;
  localparam int CNT_W  = 2*MAZE_W+1;
  localparam int N      = 1 << MAZE_W;
  localparam int CELLS  = N*N;
`ifdef MAZE_VISITED_AS_WALL_EN
  localparam bit VAW = 1'b1;
`else
  localparam bit VAW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, load_valid, load_data, maze_oe, maze_we;
  logic [MAZE_W-1:0] row, col;
  logic              load_ready, load_done, maze_in, wall_write_err, early_access_err;
  logic [CNT_W-1:0]  visited_count;

  maze_mem_responder #(.MAZE_W(MAZE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .visited_count(visited_count), .wall_write_err(wall_write_err),
    .early_access_err(early_access_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference: phase 0=post-reset, 1=loading, 2=serving.
  int m_phase, m_addr, m_cnt;
  bit m_mi, m_werr, m_eerr;
  bit m_wall[CELLS];
  bit m_vis[CELLS];
  bit rnd_pat[CELLS];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic bit pat(input int sel, input int r, input int c);
    if (sel == 0) return (r == 0 || r == N-1 || c == 0 || c == N-1);
    return rnd_pat[r*N + c];
  endfunction

  task automatic cyc();
    int i;
    if (rst) begin
      m_phase = 0; m_addr = 0; m_mi = 1; m_cnt = 0; m_werr = 0; m_eerr = 0;
    end else begin
      i = int'(row)*N + int'(col);
      if (m_phase == 2) begin
        if (maze_oe) m_mi = m_wall[i] | (VAW & m_vis[i]);
        if (maze_we) begin
          if (m_wall[i]) m_werr = 1;
          else if (!m_vis[i]) begin
            m_vis[i] = 1;
            if (m_cnt < CELLS) m_cnt++;
          end
        end
      end else begin
        m_mi = 1;
        if (maze_oe || maze_we) m_eerr = 1;
      end
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1 && load_valid) begin
        m_wall[m_addr] = load_data;
        m_vis[m_addr]  = 0;
        m_addr++;
        if (m_addr == CELLS) begin m_phase = 2; m_addr = 0; end
      end
    end
    @(posedge clk); #1;
    chk("load_ready", int'(load_ready), int'(m_phase == 1));
    chk("load_done", int'(load_done), int'(m_phase == 2));
    chk("maze_in", int'(maze_in), int'(m_mi));
    chk("visited_count", int'(visited_count), m_cnt);
    chk("wall_write_err", int'(wall_write_err), int'(m_werr));
    chk("early_access_err", int'(early_access_err), int'(m_eerr));
  endtask

  task automatic do_load(input int sel, input int limit, input bit toggle);
    int acc = 0;
    int guard = 0;
    while (acc < limit && guard < 20000) begin
      load_valid = toggle ? (guard % 2 == 1) : ($urandom_range(0, 1) == 1);
      load_data  = pat(sel, acc / N, acc % N);
      if (load_valid && m_phase == 1) acc++;
      cyc();
      guard++;
    end
    load_valid = 0;
    if (acc < limit) chk("load_timeout", acc, limit);
  endtask

  task automatic rd(input string tag, input int r, input int c, input int exp);
    row = MAZE_W'(r); col = MAZE_W'(c); maze_oe = 1;
    cyc();
    maze_oe = 0;
    chk(tag, int'(maze_in), exp);
  endtask

  task automatic wr(input int r, input int c);
    row = MAZE_W'(r); col = MAZE_W'(c); maze_we = 1;
    cyc();
    maze_we = 0;
  endtask

  task automatic rand_serve(input int n);
    for (int k = 0; k < n; k++) begin
      row     = MAZE_W'($urandom_range(0, N-1));
      col     = MAZE_W'($urandom_range(0, N-1));
      maze_oe = ($urandom_range(0, 1) == 1);
      maze_we = ($urandom_range(0, 3) == 0);
      cyc();
    end
    maze_oe = 0; maze_we = 0;
  endtask

  initial begin
    rst = 1; load_valid = 0; load_data = 0; maze_oe = 0; maze_we = 0; row = '0; col = '0;
    cyc(); cyc();
    rst = 0;
    chk("rst_first_ready", int'(load_ready), 0);
    cyc();
    chk("rst_next_ready", int'(load_ready), 1);
    chk("rst_maze_in", int'(maze_in), 1);
    chk("rst_count", int'(visited_count), 0);
    chk("rst_werr", int'(wall_write_err), 0);
    chk("rst_eerr", int'(early_access_err), 0);

    rd("early_rd_wall", 3, 3, 1);
    chk("early_err_set", int'(early_access_err), 1);

    do_load(0, CELLS, 1);
    chk("done_after_last", int'(load_done), 1);
    chk("ready_after_last", int'(load_ready), 0);

    rd("rd_0_5", 0, 5, 1);
    rd("rd_10_10", 10, 10, 0);
    rd("rd_3_3_intact", 3, 3, 0);

    wr(10, 10); wr(10, 10); wr(10, 11);
    chk("count_two", int'(visited_count), 2);
    wr(0, 0);
    chk("wall_err", int'(wall_write_err), 1);
    chk("count_still_two", int'(visited_count), 2);

    row = 20; col = 20; maze_oe = 1; maze_we = 1;
    cyc();
    maze_oe = 0; maze_we = 0;
    chk("rbw_first", int'(maze_in), 0);
    rd("rbw_second", 20, 20, VAW ? 1 : 0);

    row = 0; col = 5; row = row - 1'b1;
    maze_oe = 1;
    cyc();
    maze_oe = 0;
    chk("wrap_row_63", int'(maze_in), 1);

    rand_serve(400);

    rst = 1; cyc(); rst = 0;
    chk("serve_rst_done", int'(load_done), 0);
    chk("serve_rst_count", int'(visited_count), 0);
    for (int i = 0; i < CELLS; i++) rnd_pat[i] = ($urandom_range(0, 1) == 1);
    do_load(1, 100, 0);
    rst = 1; cyc(); cyc(); rst = 0;
    for (int i = 0; i < CELLS; i++) rnd_pat[i] = ($urandom_range(0, 1) == 1);
    do_load(1, CELLS, 0);
    chk("reload_done", int'(load_done), 1);
    rd("reload_1_1", 1, 1, int'(rnd_pat[1*N + 1]));
    rd("reload_62_62", 62, 62, int'(rnd_pat[62*N + 62]));

    rand_serve(600);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
